// File: rtl/gtx_pkg.sv
// Shared GTX link symbol constants and frame error codes, used by both the
// receive-side deframer and the transmit-side framer.
package gtx_pkg;

  localparam logic [1:0]  K_CTRL    = 2'b01;
  localparam logic [1:0]  D_CTRL    = 2'b00;
  localparam logic [15:0] IDLE_DATA = 16'h50BC;
  localparam logic [15:0] SOF_DATA  = 16'h00FB;
  localparam logic [15:0] EOF_DATA  = 16'h00FD;

  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_CSUM  = 3'd1,
    ERR_SHORT = 3'd2,
    ERR_OVF   = 3'd3,
    ERR_SOF   = 3'd4,
    ERR_BAD   = 3'd5
  } err_t;

  typedef enum logic [2:0] {
    SYM_IDLE,
    SYM_SOF,
    SYM_EOF,
    SYM_DATA,
    SYM_BAD
  } sym_class_t;

endpackage

// File: rtl/gtx_sym_dec.sv
// Combinational classifier for one received GTX word: IDLE/SOF/EOF control
// symbols, plain data, or anything unrecognised.
module gtx_sym_dec
  import gtx_pkg::*;
(
  input  logic [1:0]  ctrl_i,
  input  logic [15:0] data_i,
  output sym_class_t  sym_o
);

  always_comb begin
    sym_o = SYM_BAD;
    if (ctrl_i == D_CTRL) begin
      sym_o = SYM_DATA;
    end else if (ctrl_i == K_CTRL) begin
      case (data_i)
        IDLE_DATA: sym_o = SYM_IDLE;
        SOF_DATA:  sym_o = SYM_SOF;
        EOF_DATA:  sym_o = SYM_EOF;
        default:   sym_o = SYM_BAD;
      endcase
    end
  end

endmodule

// File: rtl/gtx_frame_rx.sv
// GTX frame receiver: locks onto the idle stream, strips SOF/EOF framing,
// emits payload words and validates the trailing XOR check word.
module gtx_frame_rx
  import gtx_pkg::*;
#(
  parameter int MAX_WORDS = 64,
  parameter int LOCK_CNT  = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [1:0]  ctrl_i,
  input  logic [15:0] data_i,
  output logic        link_up_o,
  output logic [15:0] data_o,
  output logic        valid_o,
  output logic        sof_o,
  output logic        done_o,
  output logic        ok_o,
  output logic [2:0]  err_o
);

  typedef enum logic [1:0] {ST_DOWN, ST_IDLE, ST_PAYLOAD} state_t;

  localparam int         LW      = $clog2(LOCK_CNT + 1);
  localparam logic [6:0] CNT_MAX = 7'(MAX_WORDS + 1);

  sym_class_t sym;

  state_t        state, nxt_state;
  logic [LW-1:0] lock_cnt, nxt_lock;
  logic          nxt_link, nxt_valid, nxt_sof, nxt_done, nxt_ok;
  logic [15:0]   nxt_data;
  err_t          err_q, nxt_err;
  logic [15:0]   hold, nxt_hold;
  logic          hold_v, nxt_hold_v;
  logic          first, nxt_first;
  logic [15:0]   xor_acc, nxt_xor;
  logic [6:0]    cnt, nxt_cnt;

  gtx_sym_dec u_dec (
    .ctrl_i (ctrl_i),
    .data_i (data_i),
    .sym_o  (sym)
  );

  assign err_o = err_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_DOWN;
      lock_cnt  <= '0;
      link_up_o <= 1'b0;
      data_o    <= 16'h0000;
      valid_o   <= 1'b0;
      sof_o     <= 1'b0;
      done_o    <= 1'b0;
      ok_o      <= 1'b0;
      err_q     <= ERR_NONE;
      hold      <= 16'h0000;
      hold_v    <= 1'b0;
      first     <= 1'b0;
      xor_acc   <= 16'h0000;
      cnt       <= 7'd0;
    end else begin
      state     <= nxt_state;
      lock_cnt  <= nxt_lock;
      link_up_o <= nxt_link;
      data_o    <= nxt_data;
      valid_o   <= nxt_valid;
      sof_o     <= nxt_sof;
      done_o    <= nxt_done;
      ok_o      <= nxt_ok;
      err_q     <= nxt_err;
      hold      <= nxt_hold;
      hold_v    <= nxt_hold_v;
      first     <= nxt_first;
      xor_acc   <= nxt_xor;
      cnt       <= nxt_cnt;
    end
  end

  // Every word is consumed in the cycle it arrives; the one-word hold lets
  // the check word be dropped when EOF shows up behind it.
  always_comb begin
    nxt_state  = state;
    nxt_lock   = lock_cnt;
    nxt_link   = link_up_o;
    nxt_data   = data_o;
    nxt_valid  = 1'b0;
    nxt_sof    = 1'b0;
    nxt_done   = 1'b0;
    nxt_ok     = ok_o;
    nxt_err    = err_q;
    nxt_hold   = hold;
    nxt_hold_v = hold_v;
    nxt_first  = first;
    nxt_xor    = xor_acc;
    nxt_cnt    = cnt;

    case (state)
      ST_DOWN: begin
        if (sym == SYM_IDLE) begin
          if (lock_cnt == LW'(LOCK_CNT - 1)) begin
            nxt_state = ST_IDLE;
            nxt_link  = 1'b1;
            nxt_lock  = '0;
          end else begin
            nxt_lock = lock_cnt + LW'(1);
          end
        end else begin
          nxt_lock = '0;
        end
      end

      ST_IDLE: begin
        case (sym)
          SYM_SOF: begin
            nxt_state  = ST_PAYLOAD;
            nxt_xor    = 16'h0000;
            nxt_cnt    = 7'd0;
            nxt_hold_v = 1'b0;
            nxt_first  = 1'b1;
          end
          SYM_DATA, SYM_BAD: begin
            nxt_state = ST_DOWN;
            nxt_link  = 1'b0;
            nxt_lock  = '0;
          end
          default: ;
        endcase
      end

      ST_PAYLOAD: begin
        case (sym)
          SYM_DATA: begin
            if (cnt == CNT_MAX) begin
              nxt_state  = ST_IDLE;
              nxt_done   = 1'b1;
              nxt_ok     = 1'b0;
              nxt_err    = ERR_OVF;
              nxt_hold_v = 1'b0;
            end else begin
              nxt_cnt    = cnt + 7'd1;
              nxt_xor    = xor_acc ^ data_i;
              nxt_hold   = data_i;
              nxt_hold_v = 1'b1;
              if (hold_v) begin
                nxt_data  = hold;
                nxt_valid = 1'b1;
                nxt_sof   = first;
                nxt_first = 1'b0;
              end
            end
          end
          SYM_EOF: begin
            nxt_state  = ST_IDLE;
            nxt_done   = 1'b1;
            nxt_hold_v = 1'b0;
            if (cnt < 7'd2) begin
              nxt_err = ERR_SHORT;
            end else if (xor_acc != 16'h0000) begin
              nxt_err = ERR_CSUM;
            end else begin
              nxt_err = ERR_NONE;
            end
            nxt_ok = (cnt >= 7'd2) && (xor_acc == 16'h0000);
          end
          SYM_SOF: begin
            nxt_done   = 1'b1;
            nxt_ok     = 1'b0;
            nxt_err    = ERR_SOF;
            nxt_xor    = 16'h0000;
            nxt_cnt    = 7'd0;
            nxt_hold_v = 1'b0;
            nxt_first  = 1'b1;
          end
          SYM_BAD: begin
            nxt_state  = ST_DOWN;
            nxt_link   = 1'b0;
            nxt_lock   = '0;
            nxt_done   = 1'b1;
            nxt_ok     = 1'b0;
            nxt_err    = ERR_BAD;
            nxt_hold_v = 1'b0;
          end
          default: ;
        endcase
      end

      default: nxt_state = ST_DOWN;
    endcase
  end

endmodule
